ram_bank: RTL
=============

RAM_BANK -- requirements
Module: ram_bank

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits; legal range 1..64.
REQ-002 Parameter DEPTH, default 8: number of words; power of two, minimum 2.
REQ-003 Derived localparam ADDR_W = log2(DEPTH): address width; not user-overridable.
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-005 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port in, input, WIDTH: write data.
REQ-008 Port load, input, 1: write enable for mem[address].
REQ-009 Port address, input, ADDR_W: shared read and write address.
REQ-010 Port clear, input, 1: request to zero all words.
REQ-011 Port out, output, WIDTH: read data for the word at address.
REQ-012 Port busy, output, 1: high while the clear sequencer runs.

Function
REQ-013 Storage SHALL be DEPTH words of WIDTH bits; each word is a generalisation of the single-bit load register, with load asserted meaning the word is written on the rising edge.
REQ-014 The FSM SHALL have two states, CLEAR and READY; busy SHALL be 1 exactly when the state is CLEAR (combinational decode of the state register).
REQ-015 CLEAR: each cycle, write 0 to mem[ptr] and increment ptr; when ptr == DEPTH-1, write that word and go to READY on the same edge.
REQ-016 A full clear SHALL take exactly DEPTH cycles with reset low; the first READY cycle follows the write of mem[DEPTH-1].
REQ-017 READY with clear=1: go to CLEAR with ptr=0 on the next edge; a load in the same cycle SHALL be dropped, so clear wins.
REQ-018 CLEAR with clear=1: restart with ptr=0 on the next edge; busy stays high.
REQ-019 load SHALL be ignored while in CLEAR.
REQ-020 READY with load=1 and clear=0: mem[address] <= in on the rising edge; all other words are unchanged.
REQ-021 Read is asynchronous: in READY, out = mem[address] combinationally, with no latency.
REQ-022 In CLEAR, out SHALL be all-zero regardless of address.
REQ-023 ptr SHALL be ADDR_W bits wide and SHALL NOT wrap past DEPTH-1 during a clear.

Reset
REQ-024 While reset=1 on a rising edge: state <= CLEAR, ptr <= 0; memory contents are not guaranteed to be zeroed at that edge.
REQ-025 While reset is high, busy=1 and out=0.
REQ-026 The clear sweep starts on the first edge with reset=0; all words read 0 once busy falls.
REQ-027 If reset is asserted mid-clear or mid-operation, the sweep SHALL restart from ptr=0, and any load in that cycle SHALL be discarded.
REQ-028 No asynchronous reset paths are permitted.

Configuration
REQ-029 Macro RAM_BANK_BYPASS_EN is the single compile-time option.
REQ-030 With RAM_BANK_BYPASS_EN defined: in READY with load=1 and clear=0, out = in (write-through), combinationally.
REQ-031 With RAM_BANK_BYPASS_EN undefined: out = the old mem[address] until the edge; the new value is visible from the next cycle.
REQ-032 The macro SHALL NOT alter the timing of busy, the clear sequencing, or the stored contents.

Verification
REQ-033 Reset 1 cycle, then idle (WIDTH=16, DEPTH=8) -> busy high for exactly 8 cycles after reset falls; all 8 addresses then read 0x0000.
REQ-034 READY: load=1, address=3, in=0xBEEF for 1 cycle, then read addresses 3 and 2 -> 0xBEEF and 0x0000; words 0-7 other than 3 are unchanged.
REQ-035 READY: load=1 and clear=1 in the same cycle at address 5, in=0x1234 -> busy rises next cycle for 8 cycles; address 5 reads 0x0000 afterwards.
REQ-036 Pulse clear at the 4th cycle of a sweep -> busy stays high for a total of 4+8 cycles; load pulses during busy have no effect.
REQ-037 Compare builds with and without RAM_BANK_BYPASS_EN: mem[1]=0x00AA, then load=1, address=1, in=0x0055 -> out shows 0x0055 (defined) vs 0x00AA (undefined) during the load cycle; both read 0x0055 the next cycle.
REQ-038 Assert reset for 1 cycle mid-sweep with WIDTH=8, DEPTH=16 -> busy high for 16 cycles after reset falls; all words read 0x00.

Source files
------------

// File: rtl/ram_bank.sv
// DEPTH x WIDTH register-file RAM with an asynchronous read port and a clear sequencer that zeroes every word.
// Optional compile-time feature: define RAM_BANK_BYPASS_EN for write-through of 'in' to 'out' during a load.
module ram_bank #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr_reg;
    logic [ADDR_W-1:0] ptr_next;

    logic              user_we;
    logic              sweep_we;
    logic [WIDTH-1:0]  word_q [DEPTH];
    logic [WIDTH-1:0]  rd_data;

    // State register: reset restarts the sweep from word 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= CLEAR;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Next-state logic; a clear request always restarts the sweep
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            CLEAR: begin
                if (clear) begin
                    ptr_next = '0;
                end else if (ptr_reg == LAST_PTR) begin
                    state_next = READY;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr_reg + 1'b1;
                end
            end
            READY: begin
                if (clear) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    // Output decode; user writes only land in READY and lose to clear/reset
    always_comb begin
        busy     = (state_reg == CLEAR);
        user_we  = (state_reg == READY) && load && !clear && !reset;
        sweep_we = (state_reg == CLEAR) && !clear && !reset;
    end

    // One load-register per word, addressed by either the user or the sweep pointer
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [WIDTH-1:0] word_reg;
            logic             sel_user;
            logic             sel_sweep;

            assign sel_user  = user_we  && (address == ADDR_W'(gi));
            assign sel_sweep = sweep_we && (ptr_reg == ADDR_W'(gi));

            always_ff @(posedge clk) begin
                if (sel_sweep) begin
                    word_reg <= '0;
                end else if (sel_user) begin
                    word_reg <= in;
                end
            end

            assign word_q[gi] = word_reg;
        end
    endgenerate

    assign rd_data = word_q[address];

    // Read port is combinational; contents are hidden while a sweep is in flight
    always_comb begin
`ifdef RAM_BANK_BYPASS_EN
        if (busy) begin
            out = '0;
        end else if (user_we) begin
            out = in;
        end else begin
            out = rd_data;
        end
`else
        out = busy ? '0 : rd_data;
`endif
    end

endmodule
